// File: rtl/vec_pkg.sv
// Shared vector-unit types: operand widths and the instruction-queue entry
// format consumed by vec_dec.
package vec_pkg;
   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int SEQ_W = 4;

   typedef struct packed {
      logic [ILEN-1:0]  inst;
      logic [XLEN-1:0]  rs1;
      logic [XLEN-1:0]  rs2;
      logic [SEQ_W-1:0] seq;
   } vec_iq_entry_t;
endpackage

// File: rtl/vec_fifo.sv
// Generic synchronous FIFO with a type parameter for the entry. clr has
// priority over push/pop and empties the queue without touching storage.
module vec_fifo #(
   parameter int  DEPTH = 8,
   parameter type T     = logic [7:0]
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clr,
   input  T                           wdata,
   output T                           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T                mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push & ~full & ~clr;
   assign do_pop  = pop & ~empty & ~clr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full))  else $error("vec_fifo: push while full");
         assert (!(pop && empty))  else $error("vec_fifo: pop while empty");
         assert (count_q <= CW'(DEPTH)) else $error("vec_fifo: count overflow");
         assert (count_q[PW-1:0] == PW'(wr_ptr_q - rd_ptr_q))
            else $error("vec_fifo: count disagrees with pointers");
      end
   end
endmodule

// File: rtl/vec_inst_queue.sv
// In-order instruction buffer between the scalar core and vec_dec. Tags each
// accepted entry with a wrapping sequence number that survives flush.
module vec_inst_queue
   import vec_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int XLEN  = vec_pkg::XLEN,
   parameter int ILEN  = vec_pkg::ILEN,
   parameter int SEQ_W = vec_pkg::SEQ_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clk_en,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ILEN-1:0]            in_inst,
   input  logic [XLEN-1:0]            in_rs1,
   input  logic [XLEN-1:0]            in_rs2,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ILEN-1:0]            out_inst,
   output logic [XLEN-1:0]            out_rs1,
   output logic [XLEN-1:0]            out_rs2,
   output logic [SEQ_W-1:0]           out_seq,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   typedef struct packed {
      logic [ILEN-1:0]  inst;
      logic [XLEN-1:0]  rs1;
      logic [XLEN-1:0]  rs2;
      logic [SEQ_W-1:0] seq;
   } entry_t;

   entry_t            wdata, rdata;
   logic              push, pop, clr;
   logic [SEQ_W-1:0]  seq_q, seq_d;

   // Handshakes only fire on enabled cycles; flush outranks both.
   assign in_ready  = clk_en & ~full;
   assign out_valid = clk_en & ~empty;
   assign clr       = clk_en & flush;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign wdata     = '{inst: in_inst, rs1: in_rs1, rs2: in_rs2, seq: seq_q};

   assign out_inst = rdata.inst;
   assign out_rs1  = rdata.rs1;
   assign out_rs2  = rdata.rs2;
   assign out_seq  = rdata.seq;

   always_comb begin
      seq_d = seq_q;
      if (push && !clr) seq_d = seq_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) seq_q <= '0;
      else     seq_q <= seq_d;
   end

   vec_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clr   (clr),
      .wdata (wdata),
      .rdata (rdata),
      .count (count),
      .full  (full),
      .empty (empty)
   );
endmodule
